// File: rtl/line_writeback_reader.sv
// rtl/line_writeback_reader.sv - reads one cache line from the data array and streams it out as addressed beats
// The line is captured once per request so stalls and later array writes never disturb the beats in flight.
module line_writeback_reader #(
  parameter int ID         = 0,
  parameter int data_width = 512,
  parameter int data_depth = 16,
  parameter int beat_width = 64,
  parameter int addr_width = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [$clog2(data_depth)-1:0] req_index,
  input  logic [addr_width-1:0]         req_addr,
  output logic                          arr_read_en,
  output logic [$clog2(data_depth)-1:0] arr_read_addr,
  input  logic [data_width-1:0]         arr_read_data,
  output logic                          beat_valid,
  input  logic                          beat_ready,
  output logic [beat_width-1:0]         beat_data,
  output logic [addr_width-1:0]         beat_addr,
  output logic                          beat_last,
  output logic                          busy
);

  localparam int NBEATS = data_width / beat_width;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int IW     = $clog2(data_depth);
  localparam logic [CW-1:0]         LAST_CNT   = CW'(NBEATS - 1);
  localparam logic [addr_width-1:0] BEAT_BYTES = addr_width'(beat_width / 8);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, SEND} state_t;

  state_t                               state;
  state_t                               state_next;
  logic [CW-1:0]                        cnt;
  logic [NBEATS-1:0][beat_width-1:0]    line_buf;
  logic [addr_width-1:0]                base_addr;
  logic [IW-1:0]                        read_addr_q;
  logic                                 at_last;
  logic                                 beat_fire;

  assign at_last   = (cnt == LAST_CNT);
  assign beat_fire = beat_valid && beat_ready;

  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    arr_read_en = 1'b0;
    beat_valid  = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_next = READ;
      end
      READ: begin
        arr_read_en = 1'b1;
        state_next  = CAPTURE;
      end
      CAPTURE: state_next = SEND;
      SEND: begin
        beat_valid = 1'b1;
        if (beat_ready && at_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      line_buf    <= '0;
      base_addr   <= '0;
      read_addr_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            read_addr_q <= req_index;
            base_addr   <= req_addr;
            cnt         <= '0;
          end
        end
        // Array data is only valid here, one cycle after the read strobe.
        CAPTURE: line_buf <= arr_read_data;
        SEND: begin
          if (beat_fire && !at_last) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Beat outputs are pure functions of held registers, so they stay put while stalled.
  assign arr_read_addr = read_addr_q;
  assign beat_data     = line_buf[cnt];
  assign beat_addr     = base_addr + addr_width'(cnt) * BEAT_BYTES;
  assign beat_last     = (state == SEND) && at_last;

  valid_held_until_accepted: assert property (
    @(posedge clock) disable iff (reset)
      (beat_valid && !beat_ready) |=> (beat_valid && $stable(beat_addr) && $stable(beat_data))
  ) else $error("line_writeback_reader %0d: beat changed before handshake", ID);

endmodule

// File: tb/tb_line_writeback_reader.sv
// tb/tb_line_writeback_reader.sv - scoreboard bench for line_writeback_reader
// Stimulus pushes expected beats; a negedge monitor pops and compares on every handshake.
module tb_line_writeback_reader;

  localparam int NB = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_index;
  logic [31:0]  req_addr;
  logic         arr_read_en;
  logic [3:0]   arr_read_addr;
  logic [511:0] arr_read_data;
  logic         beat_valid;
  logic         beat_ready;
  logic [63:0]  beat_data;
  logic [31:0]  beat_addr;
  logic         beat_last;
  logic         busy;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] addr;
    logic        last;
  } beat_t;

  beat_t        sb_q[$];
  logic [511:0] mem [16];
  int           applied = 0;
  int           errs = 0;
  int           hs_count = 0;
  int           rd_en_count = 0;
  bit           prev_stall = 0;
  beat_t        prev_beat;

  always #5 clock = ~clock;

  line_writeback_reader dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index), .req_addr(req_addr),
    .arr_read_en(arr_read_en), .arr_read_addr(arr_read_addr), .arr_read_data(arr_read_data),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data),
    .beat_addr(beat_addr), .beat_last(beat_last), .busy(busy)
  );

  // Array model: data appears one cycle after the strobe, junk otherwise.
  always @(posedge clock)
    arr_read_data <= arr_read_en ? mem[arr_read_addr] : {64{8'hA5}};

  function automatic logic [63:0] pat(input logic [3:0] idx, input int k);
    case (idx)
      4'd5:    pat = 64'h1111_0000_0000_0000 * k + 64'(k);
      4'd2:    pat = 64'hCAFE_0000_0000_0000 + 64'(k * 16);
      default: pat = {idx, 60'h0} + 64'(k);
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (arr_read_en) rd_en_count++;
      if (prev_stall) begin
        chk("stall_valid", 64'(beat_valid), 64'd1);
        chk("stall_data", beat_data, prev_beat.data);
        chk("stall_addr", 64'(beat_addr), 64'(prev_beat.addr));
        chk("stall_last", 64'(beat_last), 64'(prev_beat.last));
      end
      if (beat_valid && beat_ready) begin
        hs_count++;
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", 64'(beat_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          beat_t e;
          e = sb_q.pop_front();
          chk("beat_data", beat_data, e.data);
          chk("beat_addr", 64'(beat_addr), 64'(e.addr));
          chk("beat_last", 64'(beat_last), 64'(e.last));
        end
      end
      prev_stall = beat_valid && !beat_ready;
      prev_beat  = '{beat_data, beat_addr, beat_last};
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_beat_valid"}, 64'(beat_valid), 64'd0);
    chk({tag, "_arr_read_en"}, 64'(arr_read_en), 64'd0);
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
  task automatic run_line(input logic [3:0] idx, input logic [31:0] addr, input int mode,
                          input int stop_after, input bit hold_next, input logic [3:0] nidx,
                          input logic [31:0] naddr, input bit wr_after);
    int t;
    int rd0;
    int hs0;
    for (int k = 0; k < NB; k++)
      sb_q.push_back('{pat(idx, k), addr + 32'(k * 8), (k == NB - 1)});
    req_valid = 1'b1;
    req_index = idx;
    req_addr  = addr;
    chk("req_ready_before", 64'(req_ready), 64'd1);
    rd0 = rd_en_count;
    hs0 = hs_count;
    tick;
    if (hold_next) begin
      req_index = nidx;
      req_addr  = naddr;
    end else begin
      req_valid = 1'b0;
    end
    chk("rd_en_t1", 64'(arr_read_en), 64'd1);
    chk("rd_addr_t1", 64'(arr_read_addr), 64'(idx));
    chk("busy_t1", 64'(busy), 64'd1);
    chk("req_ready_t1", 64'(req_ready), 64'd0);
    tick;
    chk("rd_en_t2", 64'(arr_read_en), 64'd0);
    chk("valid_t2", 64'(beat_valid), 64'd0);
    tick;
    chk("valid_t3", 64'(beat_valid), 64'd1);
    t = 0;
    while (sb_q.size() > 0) begin
      if (stop_after > 0 && hs_count - hs0 >= stop_after) return;
      beat_ready = (mode == 0) ? 1'b1 : ((t % 3) == 0);
      tick;
      t++;
      if (wr_after && t == 1) mem[idx] = '1;
      if (t > 100) begin
        chk("beat_timeout", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
      end
    end
    beat_ready = 1'b1;
    chk("read_once", 64'(rd_en_count - rd0), 64'd1);
    chk("handshakes", 64'(hs_count - hs0), 64'(NB));
    if (mode == 0) chk("line_cycles", 64'(t), 64'(NB));
    check_idle_outputs("after_line");
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < NB; k++)
        mem[i][k*64 +: 64] = pat(4'(i), k);
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_index  = '0;
    req_addr   = '0;
    beat_ready = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check_idle_outputs("reset_idle");
      tick;
    end

    run_line(4'd5, 32'h0000_1040, 0, 0, 1'b0, 4'd0, 32'd0, 1'b0);
    run_line(4'd5, 32'h0000_1040, 1, 0, 1'b0, 4'd0, 32'd0, 1'b0);
    run_line(4'd5, 32'h0000_1040, 0, 0, 1'b0, 4'd0, 32'd0, 1'b1);
    for (int k = 0; k < NB; k++) mem[5][k*64 +: 64] = pat(4'd5, k);

    run_line(4'd5, 32'h0000_1040, 0, 3, 1'b0, 4'd0, 32'd0, 1'b0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    sb_q.delete();
    check_idle_outputs("mid_reset");
    chk("mid_reset_data", beat_data, 64'd0);
    chk("mid_reset_addr", 64'(beat_addr), 64'd0);
    chk("mid_reset_last", 64'(beat_last), 64'd0);
    chk("mid_reset_rd_addr", 64'(arr_read_addr), 64'd0);
    tick;
    run_line(4'd2, 32'h0000_2200, 0, 0, 1'b0, 4'd0, 32'd0, 1'b0);

    run_line(4'd9, 32'hFFFF_FFC0, 0, 0, 1'b1, 4'd3, 32'h0000_0400, 1'b0);
    run_line(4'd3, 32'h0000_0400, 0, 0, 1'b0, 4'd0, 32'd0, 1'b0);

    repeat (3) tick;
    chk("no_leftover", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
